// File: rtl/cached_memory_pkg.sv
// Shared definitions for the cached data-memory subsystem: FSM state
// encoding, line geometry, DRAM app command codes and a byte-enable helper.
package cached_memory_pkg;

  typedef enum logic {
    DRAM_STATE_IDLE     = 1'b0,
    DRAM_STATE_READWAIT = 1'b1
  } dram_state_e;

  localparam int LINE_BYTES     = 16;
  localparam int WORDS_PER_LINE = 4;
  localparam int WORD_BITS      = 32;

  localparam logic [2:0] APP_CMD_WRITE = 3'd0;
  localparam logic [2:0] APP_CMD_READ  = 3'd1;

  // Place a 4-bit word byte-enable at its word slot inside a 16-byte line.
  function automatic logic [LINE_BYTES-1:0] word_be_to_line(input logic [3:0] be,
                                                            input logic [1:0] word_sel);
    return LINE_BYTES'(be) << {word_sel, 2'b00};
  endfunction

endpackage

// File: rtl/cached_memory_dram.sv
// Behavioural DRAM model with an APP-style 128-bit line interface.
// Writes land in one cycle under a byte mask (mask bit 1 = byte kept);
// reads return the line DRAM_LATENCY cycles after the command together
// with a one-cycle rd_valid pulse. Reset clears only the read pipeline.
module dram_model
  import cached_memory_pkg::*;
#(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_CMD_WIDTH  = 3,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int DRAM_LINES     = 4096,
  parameter int DRAM_LATENCY   = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst_x,
  input  logic                      app_en,
  input  logic [APP_CMD_WIDTH-1:0]  app_cmd,
  input  logic [APP_ADDR_WIDTH-1:0] app_addr,
  input  logic [APP_DATA_WIDTH-1:0] app_wdf_data,
  input  logic [APP_MASK_WIDTH-1:0] app_wdf_mask,
  output logic [APP_DATA_WIDTH-1:0] app_rd_data,
  output logic                      app_rd_data_valid
);

  localparam int LINE_W = $clog2(DRAM_LINES);
  localparam int CNT_W  = $clog2(DRAM_LATENCY + 1);

  logic [APP_DATA_WIDTH-1:0] mem [DRAM_LINES] = '{default: '0};

  logic [LINE_W-1:0] line;
  logic [LINE_W-1:0] rd_line_q;
  logic [CNT_W-1:0]  rd_cnt_q;
  logic              rd_pending_q;
  logic              unused_addr_bits;

  // Upper app address bits alias onto the same backing line.
  assign line             = app_addr[LINE_W-1:0];
  assign unused_addr_bits = ^app_addr[APP_ADDR_WIDTH-1:LINE_W];

  // Masked line write; contents survive reset.
  // NOTE: storage arrays carry no reset -- clearing thousands of entries is not
  // a single-cycle operation; only control state and valid bits are reset.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (app_en && app_cmd == APP_CMD_WIDTH'(APP_CMD_WRITE)) begin
      for (int b = 0; b < APP_MASK_WIDTH; b++) begin
        if (!app_wdf_mask[b]) mem[line][8*b +: 8] <= app_wdf_data[8*b +: 8];
      end
    end
  end

  // Read pipeline: capture the line and count down the fixed latency.
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      rd_pending_q <= 1'b0;
      rd_cnt_q     <= '0;
      rd_line_q    <= '0;
    end else if (app_en && app_cmd == APP_CMD_WIDTH'(APP_CMD_READ)) begin
      rd_pending_q <= 1'b1;
      rd_cnt_q     <= CNT_W'(DRAM_LATENCY - 1);
      rd_line_q    <= line;
    end else if (rd_pending_q) begin
      if (rd_cnt_q == '0) rd_pending_q <= 1'b0;
      else                rd_cnt_q     <= rd_cnt_q - 1'b1;
    end
  end

  assign app_rd_data_valid = rd_pending_q && (rd_cnt_q == '0);
  assign app_rd_data       = mem[rd_line_q];

endmodule

// File: rtl/cached_memory.sv
// Direct-mapped, write-through, no-write-allocate data cache of 128-bit
// lines in front of dram_model. Read misses stall the core while the line
// is fetched; writes go straight to DRAM and update the cache only on a hit.
// Optional hit/miss counters: define CACHED_MEMORY_STATS_EN.
module cached_memory
  import cached_memory_pkg::*;
#(
  parameter int APP_ADDR_WIDTH = 28,
  parameter int APP_CMD_WIDTH  = 3,
  parameter int APP_DATA_WIDTH = 128,
  parameter int APP_MASK_WIDTH = 16,
  parameter int CACHE_LINES    = 64,
  parameter int DRAM_LINES     = 4096,
  parameter int DRAM_LATENCY   = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_x,
  input  logic        i_dmem_init_done,
  input  logic [3:0]  i_dmem_init_wen,
  input  logic [31:0] i_dmem_init_addr,
  input  logic [31:0] i_dmem_init_data,
  input  logic        i_dmem_ren,
  input  logic [3:0]  i_dmem_wen,
  input  logic [31:0] i_dmem_addr,
  input  logic [31:0] i_dmem_data,
  output logic [31:0] o_dmem_data,
  output logic        o_dmem_stall
`ifdef CACHED_MEMORY_STATS_EN
  ,
  output logic [31:0] o_hit_count,
  output logic [31:0] o_miss_count
`endif
);

  localparam int OFS_W = $clog2(LINE_BYTES);
  localparam int IDX_W = $clog2(CACHE_LINES);
  localparam int TAG_W = 32 - OFS_W - IDX_W;

  dram_state_e state_q, state_d;

  logic [APP_DATA_WIDTH-1:0] data_mem [CACHE_LINES];
  logic [TAG_W-1:0]          tag_mem  [CACHE_LINES];
  logic [CACHE_LINES-1:0]    valid_q;

  logic [IDX_W-1:0] idx, init_idx, fill_idx_q;
  logic [TAG_W-1:0] tag, fill_tag_q;
  logic [1:0]       word_sel;
  logic [APP_DATA_WIDTH-1:0] cur_line;
  logic [31:0]      cur_word;
  logic             hit, miss_issue, core_wr, init_wr, line_fill;
  logic             unused_addr_bits;

  logic                      app_en;
  logic [APP_CMD_WIDTH-1:0]  app_cmd;
  logic [APP_ADDR_WIDTH-1:0] app_addr;
  logic [APP_DATA_WIDTH-1:0] app_wdf_data;
  logic [APP_MASK_WIDTH-1:0] app_wdf_mask;
  logic [APP_DATA_WIDTH-1:0] app_rd_data;
  logic                      app_rd_data_valid;

  assign word_sel = i_dmem_addr[3:2];
  assign idx      = i_dmem_addr[OFS_W +: IDX_W];
  assign tag      = i_dmem_addr[31 -: TAG_W];
  assign init_idx = i_dmem_init_addr[OFS_W +: IDX_W];
  assign cur_line = data_mem[idx];
  assign cur_word = cur_line[{word_sel, 5'b0} +: 32];
  assign hit      = valid_q[idx] && (tag_mem[idx] == tag);
  assign line_fill = (state_q == DRAM_STATE_READWAIT) && app_rd_data_valid;
  assign unused_addr_bits = ^{i_dmem_addr[1:0], i_dmem_init_addr[1:0]};

  // Next-state and request decode; a write beats a simultaneous read.
  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case/if leaves it unassigned and infers a latch.
  always_comb begin
    state_d      = state_q;
    miss_issue   = i_dmem_init_done && (state_q == DRAM_STATE_IDLE) && i_dmem_ren &&
                   (i_dmem_wen == 4'b0) && !hit;
    o_dmem_stall = !i_dmem_init_done || (state_q == DRAM_STATE_READWAIT) || miss_issue;
    core_wr      = i_dmem_init_done && (i_dmem_wen != 4'b0) && !o_dmem_stall;
    init_wr      = !i_dmem_init_done && (i_dmem_init_wen != 4'b0);
    case (state_q)
      DRAM_STATE_IDLE:     if (miss_issue)        state_d = DRAM_STATE_READWAIT;
      DRAM_STATE_READWAIT: if (app_rd_data_valid) state_d = DRAM_STATE_IDLE;
      default:                                    state_d = DRAM_STATE_IDLE;
    endcase
  end

  // DRAM command mux: loader owns the port while init is not done.
  always_comb begin
    app_en  = miss_issue || core_wr || init_wr;
    app_cmd = miss_issue ? APP_CMD_WIDTH'(APP_CMD_READ) : APP_CMD_WIDTH'(APP_CMD_WRITE);
    if (i_dmem_init_done) begin
      app_addr     = APP_ADDR_WIDTH'(i_dmem_addr[31:OFS_W]);
      app_wdf_data = {WORDS_PER_LINE{i_dmem_data}};
      app_wdf_mask = ~word_be_to_line(i_dmem_wen, i_dmem_addr[3:2]);
    end else begin
      app_addr     = APP_ADDR_WIDTH'(i_dmem_init_addr[31:OFS_W]);
      app_wdf_data = {WORDS_PER_LINE{i_dmem_init_data}};
      app_wdf_mask = ~word_be_to_line(i_dmem_init_wen, i_dmem_init_addr[3:2]);
    end
  end

  assign o_dmem_data = (i_dmem_ren && hit && !o_dmem_stall) ? cur_word : 32'h0;

  // FSM state and the line/tag of the fill in flight.
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      state_q    <= DRAM_STATE_IDLE;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
    end else begin
      state_q <= state_d;
      if (miss_issue) begin
        fill_idx_q <= idx;
        fill_tag_q <= tag;
      end
    end
  end

  // Valid bits: set by a fill, cleared by a loader write (loader wins).
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      valid_q <= '0;
    end else begin
      if (line_fill) valid_q[fill_idx_q] <= 1'b1;
      if (init_wr)   valid_q[init_idx]   <= 1'b0;
    end
  end

  // Data and tag arrays: whole-line fill, or byte update on a write hit.
  always_ff @(posedge i_clk) begin
    if (line_fill) begin
      data_mem[fill_idx_q] <= app_rd_data;
      tag_mem[fill_idx_q]  <= fill_tag_q;
    end else if (core_wr && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (i_dmem_wen[b]) data_mem[idx][{word_sel, 5'b0} + 7'(8*b) +: 8] <= i_dmem_data[8*b +: 8];
      end
    end
  end

`ifdef CACHED_MEMORY_STATS_EN
  logic filled_q;
  logic rd_accept;

  assign rd_accept = i_dmem_ren && (i_dmem_wen == 4'b0) && hit && !o_dmem_stall;

  // Hit/miss counters; the read completing right after a fill is not a hit.
  always_ff @(posedge i_clk or negedge i_rst_x) begin
    if (!i_rst_x) begin
      filled_q     <= 1'b0;
      o_hit_count  <= '0;
      o_miss_count <= '0;
    end else begin
      filled_q <= line_fill;
      if (miss_issue)             o_miss_count <= o_miss_count + 1'b1;
      if (rd_accept && !filled_q) o_hit_count  <= o_hit_count + 1'b1;
    end
  end
`endif

  dram_model #(
    .APP_ADDR_WIDTH (APP_ADDR_WIDTH),
    .APP_CMD_WIDTH  (APP_CMD_WIDTH),
    .APP_DATA_WIDTH (APP_DATA_WIDTH),
    .APP_MASK_WIDTH (APP_MASK_WIDTH),
    .DRAM_LINES     (DRAM_LINES),
    .DRAM_LATENCY   (DRAM_LATENCY)
  ) u_dram (
    .i_clk             (i_clk),
    .i_rst_x           (i_rst_x),
    .app_en            (app_en),
    .app_cmd           (app_cmd),
    .app_addr          (app_addr),
    .app_wdf_data      (app_wdf_data),
    .app_wdf_mask      (app_wdf_mask),
    .app_rd_data       (app_rd_data),
    .app_rd_data_valid (app_rd_data_valid)
  );

endmodule

// File: tb/tb_cached_memory.sv
// Self-checking bench for cached_memory: directed vector table, hand-written
// reset sequences, then random traffic checked against a word-level model.
module tb_cached_memory;

  localparam int LAT = 4;

  typedef enum int {OP_RD, OP_WR, OP_INIT} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_x;
  logic        init_done;
  logic [3:0]  init_wen;
  logic [31:0] init_addr, init_data;
  logic        ren;
  logic [3:0]  wen;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic        stall;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: flat word memory plus which line each cache index holds.
  logic [31:0] ref_mem [16384];
  bit          c_valid [64];
  logic [27:0] c_line  [64];

`ifdef CACHED_MEMORY_STATS_EN
  logic [31:0] hit_count, miss_count;
  int exp_hits   = 0;
  int exp_misses = 0;
`endif

  always #5 clk = ~clk;

  cached_memory dut (
    .i_clk            (clk),
    .i_rst_x          (rst_x),
    .i_dmem_init_done (init_done),
    .i_dmem_init_wen  (init_wen),
    .i_dmem_init_addr (init_addr),
    .i_dmem_init_data (init_data),
    .i_dmem_ren       (ren),
    .i_dmem_wen       (wen),
    .i_dmem_addr      (addr),
    .i_dmem_data      (wdata),
    .o_dmem_data      (rdata),
    .o_dmem_stall     (stall)
`ifdef CACHED_MEMORY_STATS_EN
    ,
    .o_hit_count      (hit_count),
    .o_miss_count     (miss_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return c_valid[a[9:4]] && (c_line[a[9:4]] == a[31:4]);
  endfunction

  function automatic void model_fill(input logic [31:0] a);
    c_valid[a[9:4]] = 1'b1;
    c_line[a[9:4]]  = a[31:4];
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [3:0] be,
                                      input logic [31:0] d);
    for (int b = 0; b < 4; b++)
      if (be[b]) ref_mem[a[15:2]][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) c_valid[i] = 1'b0;
  endfunction

  // Core read: counts stalled cycles (bounded), then checks the returned word.
  task automatic do_read(input string name, input logic [31:0] a, input int exp_stall,
                         input logic [31:0] exp_data);
    int cycles = 0;
    init_done = 1'b1; ren = 1'b1; wen = 4'h0; addr = a;
    @(negedge clk);
    while (stall === 1'b1 && cycles <= 20) begin
      cycles++;
      @(posedge clk); #1;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, 32'(cycles), 32'(exp_stall));
    check({name, "_data"}, rdata, exp_data);
`ifdef CACHED_MEMORY_STATS_EN
    if (exp_stall == 0) exp_hits++; else exp_misses++;
`endif
    @(posedge clk); #1;
    ren = 1'b0;
    model_fill(a);
  endtask

  task automatic do_write(input string name, input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] d);
    init_done = 1'b1; ren = 1'b0; wen = be; addr = a; wdata = d;
    @(negedge clk);
    check({name, "_no_stall"}, 32'(stall), 32'h0);
    @(posedge clk); #1;
    wen = 4'h0;
    model_write(a, be, d);
  endtask

  // Read and write together: the write is taken, no miss, data only on a hit.
  task automatic do_rw(input string name, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    logic [31:0] exp_d;
    exp_d = model_hit(a) ? ref_mem[a[15:2]] : 32'h0;
    init_done = 1'b1; ren = 1'b1; wen = be; addr = a; wdata = d;
    @(negedge clk);
    check({name, "_no_stall"}, 32'(stall), 32'h0);
    check({name, "_data"}, rdata, exp_d);
    @(posedge clk); #1;
    ren = 1'b0; wen = 4'h0;
    model_write(a, be, d);
  endtask

  // Loader write; a core write to another line is driven and must be ignored.
  task automatic do_init(input string name, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] d);
    init_done = 1'b0; init_wen = be; init_addr = a; init_data = d;
    ren = 1'b1; wen = 4'hF; addr = a ^ 32'h40; wdata = ~d;
    @(negedge clk);
    check({name, "_stall"}, 32'(stall), 32'h1);
    check({name, "_data"}, rdata, 32'h0);
    @(posedge clk); #1;
    init_wen = 4'h0; ren = 1'b0; wen = 4'h0; init_done = 1'b1;
    model_write(a, be, d);
    c_valid[a[9:4]] = 1'b0;
  endtask

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{OP_RD,   32'h100, 4'h0, 32'h0,        32'h0,        LAT + 1};
    vecs[1]  = '{OP_RD,   32'h104, 4'h0, 32'h0,        32'h0,        0};
    vecs[2]  = '{OP_WR,   32'h200, 4'hF, 32'hDEADBEEF, 32'h0,        0};
    vecs[3]  = '{OP_RD,   32'h200, 4'h0, 32'h0,        32'hDEADBEEF, LAT + 1};
    vecs[4]  = '{OP_WR,   32'h200, 4'h2, 32'h0000AA00, 32'h0,        0};
    vecs[5]  = '{OP_RD,   32'h200, 4'h0, 32'h0,        32'hDEADAAEF, 0};
    vecs[6]  = '{OP_INIT, 32'h300, 4'hF, 32'h12345678, 32'h0,        0};
    vecs[7]  = '{OP_RD,   32'h300, 4'h0, 32'h0,        32'h12345678, LAT + 1};
    vecs[8]  = '{OP_RD,   32'h000, 4'h0, 32'h0,        32'h0,        LAT + 1};
    vecs[9]  = '{OP_RD,   32'h400, 4'h0, 32'h0,        32'h0,        LAT + 1};
    vecs[10] = '{OP_RD,   32'h000, 4'h0, 32'h0,        32'h0,        LAT + 1};
    vecs[11] = '{OP_RD,   32'h340, 4'h0, 32'h0,        32'h0,        LAT + 1};
    vecs[12] = '{OP_INIT, 32'h208, 4'hF, 32'h55AA55AA, 32'h0,        0};
    vecs[13] = '{OP_RD,   32'h200, 4'h0, 32'h0,        32'hDEADAAEF, LAT + 1};
    vecs[14] = '{OP_RD,   32'h208, 4'h0, 32'h0,        32'h55AA55AA, 0};

    for (int i = 0; i < 16384; i++) ref_mem[i] = 32'h0;
    model_reset();

    rst_x = 1'b0; init_done = 1'b1; init_wen = 4'h0; init_addr = 32'h0; init_data = 32'h0;
    ren = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;

    // Reset state: stall follows the combinational equation, data is zero.
    #2;
    check("rst_idle_stall", 32'(stall), 32'h0);
    check("rst_idle_data", rdata, 32'h0);
    init_done = 1'b0; #1;
    check("rst_init_stall", 32'(stall), 32'h1);
    init_done = 1'b1; ren = 1'b1; addr = 32'h100; #1;
    check("rst_miss_stall", 32'(stall), 32'h1);
    check("rst_miss_data", rdata, 32'h0);
    ren = 1'b0;
    @(posedge clk); #1;
    rst_x = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 15; i++) begin
      case (vecs[i].op)
        OP_RD:   do_read($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp_stall, vecs[i].exp_data);
        OP_WR:   do_write($sformatf("vec%0d_wr", i), vecs[i].addr, vecs[i].be, vecs[i].data);
        default: do_init($sformatf("vec%0d_init", i), vecs[i].addr, vecs[i].be, vecs[i].data);
      endcase
    end

    // Reset in the middle of a fill: state drops to IDLE at once, DRAM is kept.
    do_write("t6_wr", 32'h500, 4'hF, 32'hCAFEF00D);
    init_done = 1'b1; ren = 1'b1; wen = 4'h0; addr = 32'h500;
    repeat (3) begin @(posedge clk); #1; end
    check("t6_stall_in_fill", 32'(stall), 32'h1);
    rst_x = 1'b0; ren = 1'b0; #1;
    check("t6_rst_stall", 32'(stall), 32'h0);
    check("t6_rst_data", rdata, 32'h0);
    @(posedge clk); #1;
    rst_x = 1'b1;
    model_reset();
`ifdef CACHED_MEMORY_STATS_EN
    exp_hits = 0; exp_misses = 0;
`endif
    do_read("t6_reread", 32'h500, LAT + 1, 32'hCAFEF00D);
    do_read("t6_dram_kept", 32'h200, LAT + 1, 32'hDEADAAEF);
    do_read("t6_rehit", 32'h500, 0, 32'hCAFEF00D);

    // Random traffic over 256 lines (4 lines per index) against the model.
    for (int i = 0; i < 400; i++) begin
      int          r;
      logic [31:0] a, d;
      logic [3:0]  be;
      r  = $urandom_range(0, 99);
      a  = ($urandom_range(0, 255) << 4) | ($urandom_range(0, 3) << 2);
      d  = $urandom;
      be = 4'($urandom_range(1, 15));
      if (r < 50)      do_read($sformatf("rnd%0d_rd", i), a, model_hit(a) ? 0 : LAT + 1, ref_mem[a[15:2]]);
      else if (r < 80) do_write($sformatf("rnd%0d_wr", i), a, be, d);
      else if (r < 92) do_rw($sformatf("rnd%0d_rw", i), a, be, d);
      else             do_init($sformatf("rnd%0d_init", i), a, be, d);
    end

`ifdef CACHED_MEMORY_STATS_EN
    check("stats_hits", hit_count, 32'(exp_hits));
    check("stats_misses", miss_count, 32'(exp_misses));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cached_memory.md
Name: cached_memory

Overview:
- Data-memory subsystem for the pipelined MIPS core.
- Direct-mapped, write-through, no-write-allocate cache of 128-bit lines (4 words) in front of an internal DRAM model.
- The DRAM model uses an APP-style 128-bit line interface with fixed read latency.
- Asserts a stall to the core on read misses and during initialisation.

Parameters:
- APP_ADDR_WIDTH, 28, DRAM app address width; line address = byte address >> 4, zero-extended.
- APP_CMD_WIDTH, 3, DRAM command width (0 = write, 1 = read).
- APP_DATA_WIDTH, 128, DRAM/line data width; only 128 is supported.
- APP_MASK_WIDTH, 16, DRAM byte-mask width (APP_DATA_WIDTH/8).
- CACHE_LINES, 64, number of cache lines; must be a power of two.
- DRAM_LINES, 4096, backing-store depth in lines (64 KiB).
- DRAM_LATENCY, 4, cycles from read command to line return; must be at least 1.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_x  in  1  asynchronous active-low reset.
- i_dmem_init_done  in  1  0 = loader owns memory, 1 = normal operation.
- i_dmem_init_wen  in  4  loader byte write enables.
- i_dmem_init_addr  in  32  loader byte address, word aligned.
- i_dmem_init_data  in  32  loader write data.
- i_dmem_ren  in  1  core read request.
- i_dmem_wen  in  4  core byte write enables; bit n = bits [8n+7:8n].
- i_dmem_addr  in  32  core byte address; bits [1:0] are always 0.
- i_dmem_data  in  32  core write data.
- o_dmem_data  out  32  read data; combinational.
- o_dmem_stall  out  1  core must hold all request signals while high; combinational.

Behaviour:
- Address split:
  - word select = addr[3:2]
  - index = addr[4+log2(CACHE_LINES)-1:4]
  - tag = remaining upper bits
  - DRAM line = addr[4+log2(DRAM_LINES)-1:4]; higher bits alias.
- State machine (FSM) has two states:
  - DRAM_STATE_IDLE (0) → DRAM_STATE_READWAIT (1) on a read miss when i_dmem_init_done=1 and i_dmem_wen=0; a DRAM read is issued for the line.
  - In READWAIT, a counter runs DRAM_LATENCY cycles. On return the line is written into the cache, valid is set, tag is updated, and state returns to IDLE.
- Hit: valid[index] && tag match.
- o_dmem_stall = !i_dmem_init_done | (state==READWAIT) | (i_dmem_ren & !hit & i_dmem_wen==0 & state==IDLE).
- A read miss stalls for DRAM_LATENCY+1 cycles. The following cycle is a hit with stall=0 and valid data.
- o_dmem_data = selected word of the hit line when i_dmem_ren & hit & !o_dmem_stall; otherwise 32'h0.
- Writes are accepted only when i_dmem_wen!=0 and o_dmem_stall=0:
  - The masked bytes are written to DRAM at the same edge.
  - If the write hits, the same bytes of the cached word are updated at that edge.
  - A write miss does not allocate.
  - Writes never stall.
- If i_dmem_ren and i_dmem_wen are both active, the write wins and no miss is triggered.
- Init mode (i_dmem_init_done=0):
  - Core ren/wen are ignored and stall is held at 1.
  - A nonzero i_dmem_init_wen writes those bytes to DRAM and clears valid for the line's index.
  - A fill already in progress completes normally.
- Reset (asynchronous, mid-operation allowed):
  - All valid bits cleared, state IDLE, latency counter 0.
  - Outputs go to o_dmem_data=0; o_dmem_stall follows the combinational equation.
  - DRAM contents are preserved.
- The DRAM array initialises to all-zero at time 0.

Optional Feature:
- Macro CACHED_MEMORY_STATS_EN.
- When defined: adds outputs o_hit_count[31:0] and o_miss_count[31:0].
  - Hits count accepted reads that complete without a stall.
  - Misses count IDLE→READWAIT transitions.
  - Both counters reset to 0 on i_rst_x and wrap at 2^32.
- When undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package cached_memory_pkg:
  - state encoding DRAM_STATE_IDLE=0, DRAM_STATE_READWAIT=1
  - LINE_BYTES=16, WORDS_PER_LINE=4
  - APP command codes (read=1, write=0)
- Sub-module dram_model:
  - 128-bit × DRAM_LINES array.
  - Masked single-cycle write.
  - Read with DRAM_LATENCY and a one-cycle rd_valid pulse.
- Tag/valid/data arrays and the FSM stay in cached_memory.

Test Plan:
1. Reset, init_done=1, ren at addr 0x100 → stall high for 5 cycles (DRAM_LATENCY=4); next cycle stall=0, data=0x00000000; a repeat read of 0x104 hits in the same cycle (stall=0).
2. wen=4'hF, addr 0x200, data 0xDEADBEEF (miss, no allocate), then ren 0x200 → 5-cycle miss, then data=0xDEADBEEF.
3. After line 0x200 is cached, wen=4'b0010 with data 0x0000AA00 → next read returns 0xDEADAAEF with no stall.
4. init_done=0: init write 0x12345678 to 0x300 with stall=1 throughout; then init_done=1, ren 0x300 → miss, then 0x12345678.
5. Conflict: read 0x000 then 0x400 (same index with CACHE_LINES=64) → both miss; re-reading 0x000 misses again.
6. Assert i_rst_x low during READWAIT → state IDLE immediately; after release, a read of the same address misses (valid cleared) and returns correct data.
